// File: rtl/wptr_full_if.sv
// Write-side bus of the async FIFO pointer controller: the producer's request,
// the read-domain Gray pointer, and the write address and status returned to
// the producer and memory.
interface wptr_full_if #(
  parameter int ADDRSIZE = 4
);
  logic                winc;
  logic [ADDRSIZE:0]   rptr;
  logic [ADDRSIZE-1:0] waddr;
  logic [ADDRSIZE:0]   wptr;
  logic                wfull;
  logic                walmost_full;
  logic [ADDRSIZE:0]   wfill;
  logic                wovf;

  // Producer / surrounding FIFO side.
  modport master (
    output winc, rptr,
    input  waddr, wptr, wfull, walmost_full, wfill, wovf
  );

  // Pointer controller side.
  modport slave (
    input  winc, rptr,
    output waddr, wptr, wfull, walmost_full, wfill, wovf
  );
endinterface

// File: rtl/wptr_full.sv
// Write-domain pointer and full-flag controller for a dual-clock FIFO.
// Keeps the binary/Gray write pointers, synchronises the read Gray pointer
// into wclk, and produces registered full, almost-full, fill and overflow.
// ADDRSIZE must be at least 2 (the full compare inverts the top two bits).
module wptr_full #(
  parameter int ADDRSIZE     = 4,
  parameter int AFULL_THRESH = 14
) (
  input  logic         wclk,
  input  logic         wrst_n,
  wptr_full_if.slave   bus
);

  localparam int               DEPTH    = 1 << ADDRSIZE;
  localparam logic [ADDRSIZE:0] DEPTH_W  = (ADDRSIZE + 1)'(DEPTH);
  localparam logic [ADDRSIZE:0] THRESH_W = (ADDRSIZE + 1)'(AFULL_THRESH);

  logic [ADDRSIZE:0] wq1_rptr;
  logic [ADDRSIZE:0] wq2_rptr;
  logic [ADDRSIZE:0] wbin;
  logic [ADDRSIZE:0] wptr_q;
  logic [ADDRSIZE:0] wfill_q;
  logic              wfull_q;
  logic              walmost_full_q;
  logic              wovf_q;

  logic              winc_ok;
  logic [ADDRSIZE:0] wbinnext;
  logic [ADDRSIZE:0] wgraynext;
  logic [ADDRSIZE:0] rbin_s;
  logic [ADDRSIZE:0] fill_raw;
  logic [ADDRSIZE:0] fill_next;
  logic              full_next;
  logic              afull_next;

  // Two-flop synchroniser for the read-domain Gray pointer; nothing else sees rptr.
  // NOTE: flops take non-blocking assignments and reset asynchronously so that
  // every register updates from pre-edge values and clears without a clock.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wq1_rptr <= '0;
      wq2_rptr <= '0;
    end else begin
      wq1_rptr <= bus.rptr;
      wq2_rptr <= wq1_rptr;
    end
  end

  // Next-pointer, full compare and occupancy computed from the synchronised pointer.
  // NOTE: every output of this block is assigned on every path, so no latch is inferred.
  always_comb begin
    winc_ok   = bus.winc & ~wfull_q;
    wbinnext  = wbin + {{ADDRSIZE{1'b0}}, winc_ok};
    wgraynext = (wbinnext >> 1) ^ wbinnext;

    // Full when the next write pointer has lapped the read pointer exactly once:
    // in Gray code that is the top two bits inverted, the rest equal.
    full_next = (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]});

    // Gray-to-binary: each bit is the XOR of itself and all bits above it.
    rbin_s = '0;
    for (int i = 0; i <= ADDRSIZE; i++) begin
      rbin_s[i] = ^(wq2_rptr >> i);
    end

    fill_raw = wbinnext - rbin_s;
    // A legal read pointer never trails by more than DEPTH; the clamp only
    // matters if the read side is reset or misbehaves independently.
    fill_next  = (fill_raw > DEPTH_W) ? DEPTH_W : fill_raw;
    afull_next = (fill_next >= THRESH_W);
  end

  // Write pointer registers; a refused write leaves wbinnext equal to wbin.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin   <= '0;
      wptr_q <= '0;
    end else begin
      wbin   <= wbinnext;
      wptr_q <= wgraynext;
    end
  end

  // Registered status flags and fill level; overflow is sticky until reset.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wfull_q        <= 1'b0;
      walmost_full_q <= 1'b0;
      wfill_q        <= '0;
      wovf_q         <= 1'b0;
    end else begin
      wfull_q        <= full_next;
      walmost_full_q <= afull_next;
      wfill_q        <= fill_next;
      wovf_q         <= wovf_q | (bus.winc & wfull_q);
    end
  end

  assign bus.waddr        = wbin[ADDRSIZE-1:0];
  assign bus.wptr         = wptr_q;
  assign bus.wfull        = wfull_q;
  assign bus.walmost_full = walmost_full_q;
  assign bus.wfill        = wfill_q;
  assign bus.wovf         = wovf_q;

endmodule

// File: tb/tb_wptr_full.sv
// Directed bench for wptr_full (ADDRSIZE=4, AFULL_THRESH=14): a vector table
// covering fill and overflow, plus hand-written sequences for reset,
// release latency, simultaneous release/write and wrap-around.
`timescale 1ns/1ps
module tb_wptr_full;

  logic wclk;
  logic wrst_n;
  int   tests;
  int   fails;

  wptr_full_if #(.ADDRSIZE(4)) bus ();

  wptr_full #(.ADDRSIZE(4), .AFULL_THRESH(14)) dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .bus    (bus)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  typedef struct {
    logic       winc;
    logic [4:0] rptr;
    logic [3:0] waddr;
    logic [4:0] wptr;
    logic       afull;
    logic       full;
    logic [4:0] fill;
    logic       ovf;
  } vec_t;

  vec_t vecs [20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] gray(input int b);
    logic [4:0] v;
    v = 5'(b);
    return (v >> 1) ^ v;
  endfunction

  task automatic reset_pulse();
    @(negedge wclk);
    bus.winc = 1'b0;
    bus.rptr = 5'd0;
    wrst_n   = 1'b0;
    #1;
    wrst_n   = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " waddr"}, 32'(bus.waddr), 0);
    check({tag, " wptr"},  32'(bus.wptr), 0);
    check({tag, " wfull"}, 32'(bus.wfull), 0);
    check({tag, " afull"}, 32'(bus.walmost_full), 0);
    check({tag, " wfill"}, 32'(bus.wfill), 0);
    check({tag, " wovf"},  32'(bus.wovf), 0);
  endtask

  // Watchdog: the bench only waits on clock edges, but never let it hang.
  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] h0, h1;
    int         full_seen;

    tests = 0;
    fails = 0;

    // Fill from empty with rptr=0, then three refused writes, then idle.
    vecs[0]  = '{1'b1, 5'd0, 4'd1,  5'b00001, 1'b0, 1'b0, 5'd1,  1'b0};
    vecs[1]  = '{1'b1, 5'd0, 4'd2,  5'b00011, 1'b0, 1'b0, 5'd2,  1'b0};
    vecs[2]  = '{1'b1, 5'd0, 4'd3,  5'b00010, 1'b0, 1'b0, 5'd3,  1'b0};
    vecs[3]  = '{1'b1, 5'd0, 4'd4,  5'b00110, 1'b0, 1'b0, 5'd4,  1'b0};
    vecs[4]  = '{1'b1, 5'd0, 4'd5,  5'b00111, 1'b0, 1'b0, 5'd5,  1'b0};
    vecs[5]  = '{1'b1, 5'd0, 4'd6,  5'b00101, 1'b0, 1'b0, 5'd6,  1'b0};
    vecs[6]  = '{1'b1, 5'd0, 4'd7,  5'b00100, 1'b0, 1'b0, 5'd7,  1'b0};
    vecs[7]  = '{1'b1, 5'd0, 4'd8,  5'b01100, 1'b0, 1'b0, 5'd8,  1'b0};
    vecs[8]  = '{1'b1, 5'd0, 4'd9,  5'b01101, 1'b0, 1'b0, 5'd9,  1'b0};
    vecs[9]  = '{1'b1, 5'd0, 4'd10, 5'b01111, 1'b0, 1'b0, 5'd10, 1'b0};
    vecs[10] = '{1'b1, 5'd0, 4'd11, 5'b01110, 1'b0, 1'b0, 5'd11, 1'b0};
    vecs[11] = '{1'b1, 5'd0, 4'd12, 5'b01010, 1'b0, 1'b0, 5'd12, 1'b0};
    vecs[12] = '{1'b1, 5'd0, 4'd13, 5'b01011, 1'b0, 1'b0, 5'd13, 1'b0};
    vecs[13] = '{1'b1, 5'd0, 4'd14, 5'b01001, 1'b1, 1'b0, 5'd14, 1'b0};
    vecs[14] = '{1'b1, 5'd0, 4'd15, 5'b01000, 1'b1, 1'b0, 5'd15, 1'b0};
    vecs[15] = '{1'b1, 5'd0, 4'd0,  5'b11000, 1'b1, 1'b1, 5'd16, 1'b0};
    vecs[16] = '{1'b1, 5'd0, 4'd0,  5'b11000, 1'b1, 1'b1, 5'd16, 1'b1};
    vecs[17] = '{1'b1, 5'd0, 4'd0,  5'b11000, 1'b1, 1'b1, 5'd16, 1'b1};
    vecs[18] = '{1'b1, 5'd0, 4'd0,  5'b11000, 1'b1, 1'b1, 5'd16, 1'b1};
    vecs[19] = '{1'b0, 5'd0, 4'd0,  5'b11000, 1'b1, 1'b1, 5'd16, 1'b1};

    // ---- Power-on reset ----
    wrst_n   = 1'b0;
    bus.winc = 1'b0;
    bus.rptr = 5'd0;
    #12;
    check_all_zero("por");
    @(negedge wclk);
    wrst_n = 1'b1;

    // ---- Reset mid-operation ----
    bus.winc = 1'b1;
    repeat (5) @(posedge wclk);
    #1;
    check("pre-reset waddr", 32'(bus.waddr), 5);
    check("pre-reset wfill", 32'(bus.wfill), 5);
    @(negedge wclk);
    bus.winc = 1'b0;
    wrst_n   = 1'b0;
    #0.5;
    check_all_zero("async reset");
    #0.5;
    wrst_n = 1'b1;
    check("post-reset waddr", 32'(bus.waddr), 0);
    @(negedge wclk);
    bus.winc = 1'b1;
    @(posedge wclk);
    #1;
    check("first write after reset waddr", 32'(bus.waddr), 1);
    check("first write after reset wptr", 32'(bus.wptr), 5'b00001);

    // ---- Table: fill, overflow, sticky overflow ----
    reset_pulse();
    for (int i = 0; i < 20; i++) begin
      @(negedge wclk);
      bus.winc = vecs[i].winc;
      bus.rptr = vecs[i].rptr;
      @(posedge wclk);
      #1;
      check($sformatf("vec%0d waddr", i), 32'(bus.waddr), 32'(vecs[i].waddr));
      check($sformatf("vec%0d wptr", i),  32'(bus.wptr),  32'(vecs[i].wptr));
      check($sformatf("vec%0d afull", i), 32'(bus.walmost_full), 32'(vecs[i].afull));
      check($sformatf("vec%0d wfull", i), 32'(bus.wfull), 32'(vecs[i].full));
      check($sformatf("vec%0d wfill", i), 32'(bus.wfill), 32'(vecs[i].fill));
      check($sformatf("vec%0d wovf", i),  32'(bus.wovf),  32'(vecs[i].ovf));
    end

    // ---- Release latency: one word read, visible exactly 3 edges later ----
    @(negedge wclk);
    bus.winc = 1'b0;
    bus.rptr = 5'b00001;
    for (int e = 1; e <= 3; e++) begin
      @(posedge wclk);
      #1;
      if (e < 3) begin
        check($sformatf("release edge%0d wfull", e), 32'(bus.wfull), 1);
        check($sformatf("release edge%0d wfill", e), 32'(bus.wfill), 16);
      end else begin
        check("release wfull", 32'(bus.wfull), 0);
        check("release wfill", 32'(bus.wfill), 15);
        check("release afull", 32'(bus.walmost_full), 1);
      end
    end

    // ---- Simultaneous release and write ----
    reset_pulse();
    @(negedge wclk);
    bus.winc = 1'b1;
    repeat (16) @(posedge wclk);
    #1;
    check("sim refill wfull", 32'(bus.wfull), 1);
    check("sim refill wfill", 32'(bus.wfill), 16);
    check("sim refill wovf", 32'(bus.wovf), 0);
    @(negedge wclk);
    bus.winc = 1'b0;
    bus.rptr = 5'b00001;
    @(posedge wclk);
    #1;
    check("sim edge1 wfull", 32'(bus.wfull), 1);
    @(posedge wclk);
    #1;
    check("sim edge2 wfull", 32'(bus.wfull), 1);
    @(negedge wclk);
    bus.winc = 1'b1;
    @(posedge wclk);
    #1;
    check("sim edge3 wfull", 32'(bus.wfull), 0);
    check("sim edge3 wovf", 32'(bus.wovf), 1);
    check("sim edge3 wfill", 32'(bus.wfill), 15);
    check("sim edge3 wptr", 32'(bus.wptr), 5'b11000);
    check("sim edge3 waddr", 32'(bus.waddr), 0);
    @(posedge wclk);
    #1;
    check("sim edge4 wfull", 32'(bus.wfull), 1);
    check("sim edge4 wfill", 32'(bus.wfill), 16);
    check("sim edge4 wptr", 32'(bus.wptr), 5'b11001);
    check("sim edge4 waddr", 32'(bus.waddr), 1);

    // ---- Wrap-around with rptr trailing wptr by two edges ----
    reset_pulse();
    h0 = 5'd0;
    h1 = 5'd0;
    full_seen = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge wclk);
      bus.rptr = h1;
      h1 = h0;
      h0 = bus.wptr;
      bus.winc = 1'b1;
      @(posedge wclk);
      #1;
      if (bus.wfull) full_seen++;
      check($sformatf("wrap w%0d wptr", i), 32'(bus.wptr), 32'(gray(i)));
      if (i == 15 || i == 16 || i == 31 || i == 32)
        check($sformatf("wrap w%0d msb", i), 32'(bus.wptr[4]), 32'((i >> 4) & 1));
    end
    check("wrap waddr after 40", 32'(bus.waddr), 8);
    check("wrap wfull never set", 32'(full_seen), 0);
    @(negedge wclk);
    bus.winc = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wptr_full.md
# wptr_full

Write-domain pointer and full-flag controller for the dual-clock asynchronous FIFO. It sits directly upstream of the FIFO memory and drives its `waddr` and `wfull` inputs. It keeps the binary and Gray write pointers and synchronises the read-domain Gray pointer into `wclk`. From these it produces registered full, almost-full, fill-level and sticky-overflow status for the producer.

## Interface
- `ADDRSIZE`, 4: memory address bits; depth DEPTH = 2^ADDRSIZE; pointers are ADDRSIZE+1 bits.
- `AFULL_THRESH`, 14: almost-full threshold in words; legal range 1..DEPTH.

- `wclk`  in  1  write clock; all state is on its rising edge.
- `wrst_n`  in  1  reset, asynchronous, active-low.
- `winc`  in  1  write request from the producer; accepted only when `wfull`=0.
- `rptr`  in  ADDRSIZE+1  Gray read pointer from the read domain; asynchronous to `wclk`.
- `waddr`  out  ADDRSIZE  binary write address to the memory.
- `wptr`  out  ADDRSIZE+1  registered Gray write pointer, sent to the read domain.
- `wfull`  out  1  registered full flag.
- `walmost_full`  out  1  registered; 1 when fill ≥ AFULL_THRESH.
- `wfill`  out  ADDRSIZE+1  registered occupancy as seen from the write domain (0..DEPTH).
- `wovf`  out  1  sticky flag; set by a write attempt while full.

## Operation
- **Synchroniser.** Two flops `wq1_rptr` → `wq2_rptr` sample `rptr` on `wclk`. Only `wq2_rptr` is used downstream. No other logic touches `rptr`.
- **Write pointers.**
  - `wbin` is the ADDRSIZE+1-bit binary pointer.
  - `winc_ok` = `winc` & ~`wfull`.
  - `wbinnext` = `wbin` + `winc_ok`, modulo 2^(ADDRSIZE+1).
  - `wgraynext` = (`wbinnext`>>1) ^ `wbinnext`.
  - `wbin` ← `wbinnext` and `wptr` ← `wgraynext` on every edge.
- **Address.** `waddr` = `wbin`[ADDRSIZE-1:0], taken combinationally from the register.
- **Full.** `wfull` ← (`wgraynext` == {~`wq2_rptr`[ADDRSIZE:ADDRSIZE-1], `wq2_rptr`[ADDRSIZE-2:0]}).
- **Fill level.**
  - `rbin_s` is the Gray-to-binary conversion of `wq2_rptr` (XOR prefix from the MSB).
  - `wfill` ← (`wbinnext` − `rbin_s`) mod 2^(ADDRSIZE+1).
  - Invariant: `wfill`==DEPTH exactly when `wfull`=1. The implementation must never let `wfill` exceed DEPTH.
- **Almost-full.** `walmost_full` ← (`wbinnext` − `rbin_s`) ≥ AFULL_THRESH.
- **Overflow.** `wovf` ← `wovf` | (`winc` & `wfull`). Only reset clears it.
- **Write while full.** The write is dropped. `wbin`, `wptr`, `waddr` and `wfill` do not change because of it.
- **Wrap-around.** The pointer MSB toggles every DEPTH writes. `waddr` wraps from DEPTH-1 to 0.
- **Reset.** Asserting `wrst_n` low, including mid-transfer, immediately clears all of the following: `wq1_rptr`, `wq2_rptr`, `wbin`, `wptr`, `waddr`, `wfull`, `walmost_full`, `wfill` and `wovf`. Release is synchronous to `wclk` through the integrator's reset synchroniser.

## Timing
- **Accepted write.** If `winc`=1 and `wfull`=0 before edge N:
  - the memory stores data at the old `waddr` on edge N;
  - `waddr`, `wptr` and `wfill` update after edge N.
- **Full on last write.** `wfull` rises on the same edge that accepts the write filling slot DEPTH. The next cycle's `winc` is then refused. Zero-cycle full latency is required.
- **Full release.** A change on `rptr` is seen in `wfull`, `wfill` and `walmost_full` after 3 `wclk` edges: sample, sync, register. Sampling skew can add up to 1 more edge. Full release is therefore pessimistic and never early.
- **Simultaneous events.** A write is decided only by `wfull` as it stood before the edge. This holds even if `wfull` deasserts on that same edge. A concurrent read release and write may leave `wfill` unchanged.
- **Status stability.** All outputs except `waddr` come straight from registers. `waddr` is a register slice. There are no combinational paths from `rptr` to any output.

## Test plan
1. **Reset mid-operation.** After 5 writes, pulse `wrst_n` low for 1 ns between edges → all outputs 0 immediately. After release, the first write goes to `waddr`=0.
2. **Fill.** ADDRSIZE=4 and `rptr`=0; apply 16 consecutive `winc` →
   - `waddr` steps 0..15;
   - `wptr` follows the Gray sequence (5'b00001, 00011, 00010, ...);
   - `walmost_full`=1 after the 14th edge;
   - `wfull`=1 and `wfill`=16 after the 16th edge.
3. **Overflow.** From full, hold `winc` for 3 cycles → `waddr`=0, `wptr`=5'b11000 and `wfill`=16 all unchanged; `wovf`=1 and stays 1 after `winc` drops.
4. **Release latency.** From full, set `rptr`=5'b00001 (one word read) → `wfull` falls and `wfill`=15 exactly 3 edges later. `walmost_full` stays 1.
5. **Wrap-around.** Drive `rptr` to track `wptr` with a 2-edge lag and write 40 words → `wptr` MSB toggles after writes 16 and 32; `waddr` reads 8 after write 40; `wfull` never asserts.
6. **Simultaneous.** With `wfull`=1, assert `winc` on the edge where `wfull` deasserts → that write is dropped (`wovf` set). `winc` on the following edge is accepted: `wfull` re-asserts and `wfill`=16.
